ex_operand_issue: RTL

ID/EX pipeline stage that produces the `alu_op`/`operand_1`/`operand_2` interface consumed by the EX-stage ALU. It registers decoded instruction fields on each clock, decodes main-control ALUOp plus funct into the 4-bit ALU opcode, and selects the final operands through EX/MEM and MEM/WB forwarding muxes. Hazard logic elsewhere drives `stall` and `flush`; this block obeys them.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/alu_control.sv | 33 +++
 rtl/ex_operand_issue.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes, main-control ALUOp codes,
// R-type funct values and the ID/EX register layout.
package mips_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_op_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_OR    = 2'b11
   } aluop_e;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;
   localparam logic [5:0] FUNCT_NOR = 6'h27;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  write_reg;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
   } idex_t;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: main-control ALUOp plus funct to 4-bit ALU opcode.
module alu_control
   import mips_pkg::*;
(
   input  logic [1:0] id_alu_ctrl,
   input  logic [5:0] id_funct,
   output logic [3:0] alu_op,
   output logic       illegal
);

   always_comb begin
      alu_op  = ALU_AND;
      illegal = 1'b0;
      case (aluop_e'(id_alu_ctrl))
         ALUOP_ADD: alu_op = ALU_ADD;
         ALUOP_SUB: alu_op = ALU_SUB;
         ALUOP_OR:  alu_op = ALU_OR;
         ALUOP_FUNCT: begin
            case (id_funct)
               FUNCT_ADD: alu_op = ALU_ADD;
               FUNCT_SUB: alu_op = ALU_SUB;
               FUNCT_AND: alu_op = ALU_AND;
               FUNCT_OR:  alu_op = ALU_OR;
               FUNCT_SLT: alu_op = ALU_SLT;
               FUNCT_NOR: alu_op = ALU_NOR;
               default:   illegal = 1'b1;
            endcase
         end
         default: alu_op = ALU_AND;
      endcase
   end

endmodule

// File: rtl/ex_operand_issue.sv
// ID/EX register with ALU control decode and EX/MEM, MEM/WB operand forwarding.
module ex_operand_issue
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [1:0]  id_alu_ctrl,
   input  logic [5:0]  id_funct,
   input  logic        id_alu_src,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_dst,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic [3:0]  alu_op,
   output logic [31:0] operand_1,
   output logic [31:0] operand_2,
   output logic [31:0] ex_store_data,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic [4:0]  ex_write_reg,
   output logic        ex_illegal
);

   idex_t      idex_q, idex_d;
   logic [3:0] dec_op;
   logic       dec_illegal;
   logic [31:0] fwd_rs, fwd_rt;

   alu_control u_alu_control (
      .id_alu_ctrl (id_alu_ctrl),
      .id_funct    (id_funct),
      .alu_op      (dec_op),
      .illegal     (dec_illegal)
   );

   always_comb begin
      idex_d = idex_q;
      if (flush || (!stall && !id_valid)) begin
         idex_d = '0;
      end else if (!stall) begin
         idex_d.valid      = 1'b1;
         idex_d.illegal    = dec_illegal;
         idex_d.alu_op     = dec_op;
         idex_d.alu_src    = id_alu_src;
         // An unsupported funct must not modify architectural state.
         idex_d.reg_write  = id_reg_write & ~dec_illegal;
         idex_d.mem_read   = id_mem_read  & ~dec_illegal;
         idex_d.mem_write  = id_mem_write & ~dec_illegal;
         idex_d.mem_to_reg = id_mem_to_reg;
         idex_d.rs         = id_rs;
         idex_d.rt         = id_rt;
         idex_d.write_reg  = id_reg_dst ? id_rd : id_rt;
         idex_d.rs_data    = id_rs_data;
         idex_d.rt_data    = id_rt_data;
         idex_d.imm        = id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) idex_q <= '0;
      else       idex_q <= idex_d;
   end

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] reg_data,
                                       input logic em_we, input logic [4:0] em_rd,
                                       input logic [31:0] em_res, input logic mw_we,
                                       input logic [4:0] mw_rd, input logic [31:0] mw_res);
      if (idx != '0 && em_we && em_rd == idx)      return em_res;
      else if (idx != '0 && mw_we && mw_rd == idx) return mw_res;
      else                                         return reg_data;
   endfunction

   always_comb begin
      fwd_rs = fwd(idex_q.rs, idex_q.rs_data, exmem_reg_write, exmem_rd, exmem_result,
                   memwb_reg_write, memwb_rd, memwb_result);
      fwd_rt = fwd(idex_q.rt, idex_q.rt_data, exmem_reg_write, exmem_rd, exmem_result,
                   memwb_reg_write, memwb_rd, memwb_result);
   end

   assign alu_op        = idex_q.alu_op;
   assign operand_1     = fwd_rs;
   assign operand_2     = idex_q.alu_src ? idex_q.imm : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_valid      = idex_q.valid;
   assign ex_reg_write  = idex_q.reg_write;
   assign ex_mem_read   = idex_q.mem_read;
   assign ex_mem_write  = idex_q.mem_write;
   assign ex_mem_to_reg = idex_q.mem_to_reg;
   assign ex_write_reg  = idex_q.write_reg;
   assign ex_illegal    = idex_q.illegal;

endmodule
